ieee_adder_sequencer: RTL and testbench

IEEE_ADDER_SEQUENCER -- requirements
Module: ieee_adder_sequencer

---
 rtl/ieee_adder_sequencer_pkg.sv | 35 +++
 rtl/ieee_adder_sequencer_rr_arbiter.sv | 41 ++++
 rtl/ieee_adder_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_ieee_adder_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ieee_adder_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ieee_adder_sequencer_pkg                                  |
// | Purpose  : Shared widths, bit positions and FSM state encodings for  |
// |            the multi-cycle single-precision adder sequencer.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ieee_adder_sequencer_pkg;

  // Word layout of an IEEE-754 single-precision value
  localparam int C_WORD_W   = 32;
  localparam int C_EXP_W    = 8;
  localparam int C_FRAC_W   = 23;
  localparam int C_SIGN_BIT = 31;
  localparam int C_EXP_LSB  = 23;

  // Working significand: hidden bit + fraction + guard bits
  localparam int C_GUARD_W  = 3;
  localparam int C_SIG_W    = 27;

  localparam logic [C_EXP_W-1:0] C_EXP_MAX = 8'hFF;

  // Sequencer states, one per cycle
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CMP  = 3'd2,
    ST_ADD  = 3'd3,
    ST_NORM = 3'd4,
    ST_PACK = 3'd5,
    ST_OUT  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ieee_adder_sequencer_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ieee_adder_rr_arbiter                                     |
// | Purpose  : Two-way round-robin grant with a single priority bit.     |
// |            Priority passes to the other requester after each grant.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ieee_adder_rr_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // r_prio = index of the requester that wins a tie
  logic r_prio;

  // Grant the lone requester, or the priority holder on a tie
  always_comb begin
    gnt0 = en && req0 && (!req1 || !r_prio);
    gnt1 = en && req1 && (!req0 ||  r_prio);
  end

  // Hand priority to the requester that was not just served
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= (RR_INIT != 0);
    end else if (gnt0) begin
      r_prio <= 1'b1;
    end else if (gnt1) begin
      r_prio <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ieee_adder_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ieee_adder_sequencer                                      |
// | Purpose  : Two-requester, multi-cycle IEEE-754 single add/subtract.  |
// |            Round toward zero, overflow saturates to infinity.        |
// |            IEEE_ADDER_NORMALIZE_EN adds a left-normalising NORM      |
// |            state; without it results may be packed unnormalised.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ieee_adder_sequencer
  import ieee_adder_sequencer_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        res_ovf,
  output logic        res_unnorm
);

  state_t r_state, w_next;
  logic   w_gnt0, w_gnt1, w_accept;

  // Latched request
  logic [C_WORD_W-1:0] r_op_a, r_op_b;
  logic                r_sub, r_id;
  // Unpacked operands
  logic                r_a_sign, r_b_sign;
  logic [C_EXP_W-1:0]  r_a_exp, r_b_exp;
  logic [C_SIG_W-1:0]  r_a_sig, r_b_sig;
  // Ordered operands and working result
  logic                r_big_sign, r_small_sign, r_sign, r_ovf;
  logic [C_SIG_W-1:0]  r_big_sig, r_small_sig, r_sig;
  logic [C_EXP_W-1:0]  r_exp, r_shift;
  // Adder stage
  logic [C_SIG_W-1:0]  w_aligned, w_add_sig;
  logic [C_SIG_W:0]    w_sum;
  logic [C_EXP_W:0]    w_add_exp;
  logic                w_add_ovf;

  // Arbitration is only open in IDLE and never while reset is held
  ieee_adder_rr_arbiter #(.RR_INIT(RR_INIT)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((r_state == ST_IDLE) && rst_n),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0  (w_gnt0),
    .gnt1  (w_gnt1)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_accept   = w_gnt0 || w_gnt1;

  // Align, add or subtract, and fold a carry-out back into range
  always_comb begin
    w_aligned = (r_shift >= C_EXP_W'(C_SIG_W)) ? '0 : (r_small_sig >> r_shift);
    if (r_big_sign == r_small_sign) begin
      w_sum = {1'b0, r_big_sig} + {1'b0, w_aligned};
    end else begin
      // Ordering guarantees big >= aligned, so no borrow
      w_sum = {1'b0, r_big_sig} - {1'b0, w_aligned};
    end
    if (w_sum[C_SIG_W]) begin
      w_add_sig = w_sum[C_SIG_W:1];
      w_add_exp = {1'b0, r_exp} + 1'b1;
    end else begin
      w_add_sig = w_sum[C_SIG_W-1:0];
      w_add_exp = {1'b0, r_exp};
    end
    w_add_ovf = (w_add_exp >= {1'b0, C_EXP_MAX});
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and result-valid decode
  always_comb begin
    w_next    = r_state;
    res_valid = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_PREP;
      ST_PREP: w_next = ST_CMP;
      ST_CMP:  w_next = ST_ADD;
`ifdef IEEE_ADDER_NORMALIZE_EN
      ST_ADD: begin
        // Overflow and exact cancellation skip normalisation
        if (!w_add_ovf && (w_add_sig != '0) && !w_add_sig[C_SIG_W-1] &&
            (w_add_exp != '0))
          w_next = ST_NORM;
        else
          w_next = ST_PACK;
      end
      // Stay only while the shift about to happen still leaves bit 26 clear
      ST_NORM: w_next = ((r_exp > 8'd1) && !r_sig[C_SIG_W-2]) ? ST_NORM : ST_PACK;
`else
      ST_ADD:  w_next = ST_PACK;
`endif
      ST_PACK: w_next = ST_OUT;
      ST_OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: one stage of work per state, result registers loaded in PACK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_a <= '0; r_op_b <= '0; r_sub <= 1'b0; r_id <= 1'b0;
      r_a_sign <= 1'b0; r_b_sign <= 1'b0; r_a_exp <= '0; r_b_exp <= '0;
      r_a_sig <= '0; r_b_sig <= '0;
      r_big_sign <= 1'b0; r_small_sign <= 1'b0; r_sign <= 1'b0; r_ovf <= 1'b0;
      r_big_sig <= '0; r_small_sig <= '0; r_sig <= '0; r_exp <= '0; r_shift <= '0;
      res_data <= '0; res_id <= 1'b0; res_ovf <= 1'b0; res_unnorm <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0) begin
            r_op_a <= req0_a; r_op_b <= req0_b; r_sub <= req0_sub; r_id <= 1'b0;
          end else if (w_gnt1) begin
            r_op_a <= req1_a; r_op_b <= req1_b; r_sub <= req1_sub; r_id <= 1'b1;
          end
        end
        ST_PREP: begin
          r_a_sign <= r_op_a[C_SIGN_BIT];
          r_b_sign <= r_op_b[C_SIGN_BIT] ^ r_sub;
          r_a_exp  <= r_op_a[C_EXP_LSB +: C_EXP_W];
          r_b_exp  <= r_op_b[C_EXP_LSB +: C_EXP_W];
          r_a_sig  <= {(r_op_a[C_EXP_LSB +: C_EXP_W] != '0), r_op_a[C_FRAC_W-1:0],
                       {C_GUARD_W{1'b0}}};
          r_b_sig  <= {(r_op_b[C_EXP_LSB +: C_EXP_W] != '0), r_op_b[C_FRAC_W-1:0],
                       {C_GUARD_W{1'b0}}};
        end
        ST_CMP: begin
          if ({r_a_exp, r_a_sig} >= {r_b_exp, r_b_sig}) begin
            r_big_sign <= r_a_sign; r_big_sig <= r_a_sig;
            r_small_sign <= r_b_sign; r_small_sig <= r_b_sig;
            r_exp <= r_a_exp; r_shift <= r_a_exp - r_b_exp;
          end else begin
            r_big_sign <= r_b_sign; r_big_sig <= r_b_sig;
            r_small_sign <= r_a_sign; r_small_sig <= r_a_sig;
            r_exp <= r_b_exp; r_shift <= r_b_exp - r_a_exp;
          end
        end
        ST_ADD: begin
          r_sign <= r_big_sign;
          r_sig  <= w_add_sig;
          r_exp  <= w_add_exp[C_EXP_W-1:0];
          r_ovf  <= w_add_ovf;
        end
`ifdef IEEE_ADDER_NORMALIZE_EN
        ST_NORM: begin
          if (r_exp > 8'd1) begin
            r_sig <= r_sig << 1;
            r_exp <= r_exp - 8'd1;
          end else begin
            // Cannot go below the minimum exponent: becomes a denormal
            r_exp <= '0;
          end
        end
`endif
        ST_PACK: begin
          res_id <= r_id;
          if (r_ovf) begin
            res_data   <= {r_sign, C_EXP_MAX, {C_FRAC_W{1'b0}}};
            res_ovf    <= 1'b1;
            res_unnorm <= 1'b0;
          end else if (r_sig == '0) begin
            // Exact cancellation always gives +0
            res_data   <= '0;
            res_ovf    <= 1'b0;
            res_unnorm <= 1'b0;
          end else begin
            res_data   <= {r_sign, r_exp, r_sig[C_SIG_W-2 -: C_FRAC_W]};
            res_ovf    <= 1'b0;
`ifdef IEEE_ADDER_NORMALIZE_EN
            res_unnorm <= 1'b0;
`else
            res_unnorm <= !r_sig[C_SIG_W-1] && (r_exp != '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ieee_adder_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ieee_adder_sequencer                                   |
// | Purpose  : Directed scoreboard bench for ieee_adder_sequencer.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ieee_adder_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_id, res_ovf, res_unnorm;
  logic [31:0] res_data;

  ieee_adder_sequencer #(.RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_ovf(res_ovf), .res_unnorm(res_unnorm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic        ovf;
    logic        un;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  logic [31:0] e_data [2];
  logic        e_ovf  [2];
  logic        e_un   [2];
  int          e_lat  [2];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          n_res  = 0;
  logic        prev_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push expectations on accept, compare on result handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        check("single_grant0", 32'(req1_ready), 32'd0);
        sb.push_back('{e_data[0], 1'b0, e_ovf[0], e_un[0], e_lat[0], cyc});
        grants.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        check("single_grant1", 32'(req0_ready), 32'd0);
        sb.push_back('{e_data[1], 1'b1, e_ovf[1], e_un[1], e_lat[1], cyc});
        grants.push_back(1);
      end
      if (res_valid && !prev_v) begin
        if (sb.size() == 0) check("unexpected_result", 32'(sb.size()), 32'd1);
        else                check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
      end
      if (res_valid && res_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("res_data",   res_data,          e.data);
        check("res_id",     32'(res_id),       32'(e.id));
        check("res_ovf",    32'(res_ovf),      32'(e.ovf));
        check("res_unnorm", 32'(res_unnorm),   32'(e.un));
        n_res++;
      end
    end
    prev_v <= res_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] ed, input logic eo,
                         input logic eu, input int el);
    e_data[n] = ed; e_ovf[n] = eo; e_un[n] = eu; e_lat[n] = el;
    if (n == 0) begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
  endtask

  task automatic wait_grants(input int target);
    int k = 0;
    while (grants.size() < target && k < 200) begin tick(); k++; end
    check("grant_count", 32'(grants.size()), 32'(target));
  endtask

  task automatic wait_results(input int target);
    int k = 0;
    while (n_res < target && k < 200) begin tick(); k++; end
    check("result_count", 32'(n_res), 32'(target));
  endtask

  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] ed, input logic eo,
                       input logic eu, input int el);
    int g0 = grants.size();
    set_req(n, a, b, sub, ed, eo, eu, el);
    wait_grants(g0 + 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int g0;
    int k;
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_data[i] = '0; e_ovf[i] = 1'b0; e_un[i] = 1'b0; e_lat[i] = 5;
    end
    repeat (3) tick();

    // Reset state, with a request pending that must not be granted
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_res_data",   res_data,        32'h0);
    check("rst_res_id",     32'(res_id),     32'd0);
    check("rst_res_ovf",    32'(res_ovf),    32'd0);
    check("rst_res_unnorm", 32'(res_unnorm), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1.0 + 1.0
    issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 5);
    wait_results(1);

    // 1.5 - 1.0 leaves an unnormalised 0.5
`ifdef IEEE_ADDER_NORMALIZE_EN
    issue(1, 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 6);
`else
    issue(1, 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3FC00000, 1'b0, 1'b1, 5);
`endif
    wait_results(2);

    // Exact cancellation
    issue(0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 5);
    wait_results(3);

    // Overflow to +inf
    issue(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 5);
    wait_results(4);

    // Both requesters busy; first result back-pressured for 3 cycles
    g0 = grants.size();
    res_ready = 1'b0;
    set_req(0, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 5);
    set_req(1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 5);
    k = 0;
    while (!res_valid && k < 50) begin tick(); k++; end
    for (int i = 0; i < 3; i++) begin
      check("stall_valid",  32'(res_valid),  32'd1);
      check("stall_data",   res_data,        32'h40800000);
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_ready1", 32'(req1_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    k = 0;
    while (grants.size() < g0 + 4 && k < 200) begin tick(); k++; end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_results(8);
    check("grant_order0", 32'(grants[g0]),     32'd0);
    check("grant_order1", 32'(grants[g0 + 1]), 32'd1);
    check("grant_order2", 32'(grants[g0 + 2]), 32'd0);
    check("grant_order3", 32'(grants[g0 + 3]), 32'd1);

    // Reset while the operation is in ADD
    issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 5);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    sb.delete();
    rst_n = 1'b1;
    repeat (8) tick();
    check("no_result_after_reset", 32'(n_res), 32'd8);
    check("valid_low_after_reset", 32'(res_valid), 32'd0);

    // Fresh contention after reset: priority back at RR_INIT
    g0 = grants.size();
    set_req(0, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 5);
    set_req(1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 5);
    wait_grants(g0 + 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("post_reset_grant", 32'(grants[g0]), 32'd0);
    wait_results(9);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
